// File: rtl/seq_decomp_pkg.sv
// Shared types and widths for the sequence decomposer datapath.
// State encoding for the per-sample conversion sequencer.
package seq_decomp_pkg;

  localparam int DATA_W     = 12;
  localparam int ADDR_W     = 4;
  localparam int MAX_DAC_CH = 4;
  localparam int CH_W       = $clog2(MAX_DAC_CH);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ADC,
    SCE,
    DAC,
    DAC_NEXT
  } state_e;

  function automatic logic is_phase(state_e s);
    return (s == ADC) || (s == SCE) || (s == DAC);
  endfunction

endpackage

// File: rtl/conv_cycle_scheduler_if.sv
// Enable/done handshakes and data buses between the scheduler
// and the ADC boards, sequence engine and DAC writer.
interface conv_cycle_scheduler_if;
  import seq_decomp_pkg::*;

  logic                         adc_done_b1;
  logic                         adc_done_b2;
  logic                         adc_enable;
  logic                         sce_done;
  logic                         sce_enable;
  logic [MAX_DAC_CH*DATA_W-1:0] ch_data;
  logic                         dac_done;
  logic                         dac_enable;
  logic [DATA_W-1:0]            dac_data;
  logic [ADDR_W-1:0]            dac_address;

  modport master (
    input  adc_done_b1,
    input  adc_done_b2,
    output adc_enable,
    input  sce_done,
    output sce_enable,
    input  ch_data,
    input  dac_done,
    output dac_enable,
    output dac_data,
    output dac_address
  );

  modport slave (
    output adc_done_b1,
    output adc_done_b2,
    input  adc_enable,
    output sce_done,
    input  sce_enable,
    output ch_data,
    output dac_done,
    input  dac_enable,
    input  dac_data,
    input  dac_address
  );

endinterface

// File: rtl/sample_timer.sv
// Free-running sample-period divider; tick marks the last clock
// of each period and the count is held at zero while stopped.
module sample_timer #(
  parameter int SAMPLE_DIV = 2500
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = run && (count_q == LAST);

  always_comb begin
    count_d = '0;
    if (run && !tick) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv_cycle_scheduler.sv
// Per-sample sequencer: ADC pair, sequence engine, then one DAC
// write per channel, with overrun and phase watchdog detection.
module conv_cycle_scheduler
  import seq_decomp_pkg::*;
#(
  parameter int SAMPLE_DIV    = 2500,
  parameter int NUM_DAC_CH    = 3,
  parameter int DAC_ADDR_BASE = 0,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 err_clr,
  conv_cycle_scheduler_if.master bus,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic [15:0]          cycle_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_DAC_CH - 1);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(DAC_ADDR_BASE);

  state_e state_q;
  state_e state_d;

  logic b1_q;
  logic b1_d;
  logic b2_q;
  logic b2_d;

  logic [DATA_W-1:0] snap_q [MAX_DAC_CH];
  logic [DATA_W-1:0] snap_d [MAX_DAC_CH];

  logic [CH_W-1:0]   k_q;
  logic [CH_W-1:0]   k_d;
  logic [DATA_W-1:0] dac_data_q;
  logic [DATA_W-1:0] dac_data_d;
  logic [ADDR_W-1:0] dac_addr_q;
  logic [ADDR_W-1:0] dac_addr_d;
  logic [WD_W-1:0]   wd_q;
  logic [WD_W-1:0]   wd_d;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;
  logic              ovr_q;
  logic              ovr_d;
  logic              terr_q;
  logic              terr_d;

  logic tick;
  logic phase;
  logic wd_expired;
  logic timeout_set;

  sample_timer #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tick (tick)
  );

  assign phase      = is_phase(state_q);
  assign wd_expired = phase && (wd_q == WD_LAST);
  assign busy       = (state_q != IDLE) && (state_q != WAIT_TICK);

  assign bus.adc_enable  = (state_q == ADC);
  assign bus.sce_enable  = (state_q == SCE);
  assign bus.dac_enable  = (state_q == DAC);
  assign bus.dac_data    = dac_data_q;
  assign bus.dac_address = dac_addr_q;

  assign overrun     = ovr_q;
  assign timeout_err = terr_q;
  assign cycle_count = cnt_q;

  always_comb begin
    state_d     = state_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    snap_d      = snap_q;
    k_d         = k_q;
    dac_data_d  = dac_data_q;
    dac_addr_d  = dac_addr_q;
    cnt_d       = cnt_q;
    timeout_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!run) begin
          state_d = IDLE;
        end else if (tick) begin
          state_d = ADC;
        end
      end
      ADC: begin
        // boards may finish on different cycles
        b1_d = b1_q | bus.adc_done_b1;
        b2_d = b2_q | bus.adc_done_b2;
        if (b1_d && b2_d) begin
          state_d = SCE;
          b1_d    = 1'b0;
          b2_d    = 1'b0;
        end
      end
      SCE: begin
        if (bus.sce_done) begin
          for (int i = 0; i < MAX_DAC_CH; i++) begin
            snap_d[i] = bus.ch_data[i*DATA_W +: DATA_W];
          end
          k_d        = '0;
          dac_data_d = snap_d[0];
          dac_addr_d = ADDR_BASE;
          state_d    = DAC;
        end
      end
      DAC: begin
        if (bus.dac_done) state_d = DAC_NEXT;
      end
      DAC_NEXT: begin
        if (k_q < LAST_CH) begin
          k_d        = k_q + 1'b1;
          dac_data_d = snap_q[k_d];
          dac_addr_d = ADDR_BASE + ADDR_W'(k_d);
          state_d    = DAC;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = run ? WAIT_TICK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // a stalled phase abandons the cycle without counting it
    if (wd_expired) begin
      timeout_set = 1'b1;
      b1_d        = 1'b0;
      b2_d        = 1'b0;
      state_d     = run ? WAIT_TICK : IDLE;
    end
  end

  always_comb begin
    wd_d = '0;
    if (phase && (state_d == state_q)) begin
      wd_d = wd_q + 1'b1;
    end
    ovr_d  = (ovr_q && !err_clr) || (tick && busy);
    terr_d = (terr_q && !err_clr) || timeout_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      b1_q       <= 1'b0;
      b2_q       <= 1'b0;
      snap_q     <= '{default: '0};
      k_q        <= '0;
      dac_data_q <= '0;
      dac_addr_q <= '0;
      wd_q       <= '0;
      cnt_q      <= '0;
      ovr_q      <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      snap_q     <= snap_d;
      k_q        <= k_d;
      dac_data_q <= dac_data_d;
      dac_addr_q <= dac_addr_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
      terr_q     <= terr_d;
    end
  end

endmodule
